fixed_to_float: RTL and testbench



---
 rtl/cordic_pkg.sv | 24 ++
 rtl/fx2fl_round_pack.sv | 38 +++
 rtl/fixed_to_float.sv | 120 ++++++++++++
 tb/tb_fixed_to_float.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: Q2.30 fixed-point format, IEEE-754 single fields,
// and the fixed_to_float FSM state type.
package cordic_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned FRAC_BITS  = 30;
  localparam int unsigned EXP_BIAS   = 127;
  localparam int unsigned MANT_BITS  = 23;
  localparam int unsigned EXP_OFFSET = EXP_BIAS + WIDTH - 1 - FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    PACK,
    OUT
  } f2f_state_e;

  typedef struct packed {
    logic                 sign;
    logic [7:0]           exp;
    logic [MANT_BITS-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fx2fl_round_pack.sv
// Packs a normalised magnitude and shift count into an IEEE-754 single,
// rounding to nearest-even on the bits below the 23-bit fraction.
module fx2fl_round_pack
  import cordic_pkg::*;
#(
  parameter int unsigned MAG_W   = 32,
  parameter int unsigned S_W     = 5,
  parameter int unsigned EXP_TOP = EXP_OFFSET
) (
  input  logic             sign,
  input  logic [MAG_W-1:0] mag,
  input  logic [S_W-1:0]   s,
  output logic [31:0]      result_c
);

  logic [MANT_BITS-1:0] frac;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [MANT_BITS:0]   frac_rnd;
  logic [7:0]           exp;
  fp32_t                fp;

  // Hidden one sits at mag[MAG_W-1]; a fraction carry bumps the exponent.
  always_comb begin
    frac     = mag[MAG_W-2 -: MANT_BITS];
    guard    = mag[MAG_W-2-MANT_BITS];
    sticky   = |mag[MAG_W-3-MANT_BITS:0];
    round_up = guard & (sticky | frac[0]);
    frac_rnd = {1'b0, frac} + (MANT_BITS+1)'(round_up);
    exp      = 8'(EXP_TOP) - 8'(s) + 8'(frac_rnd[MANT_BITS]);
    fp.sign  = sign;
    fp.exp   = exp;
    fp.frac  = frac_rnd[MANT_BITS-1:0];
    result_c = (mag == '0) ? 32'h0000_0000 : 32'(fp);
  end

endmodule

// File: rtl/fixed_to_float.sv
// Signed Q2.30 fixed-point to IEEE-754 single converter with valid/ready on both sides.
// FIXED_TO_FLOAT_FAST_NORM_EN selects single-cycle normalisation instead of 1 bit/cycle.
module fixed_to_float #(
  parameter int unsigned WIDTH     = cordic_pkg::WIDTH,
  parameter int unsigned FRAC_BITS = cordic_pkg::FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data
);

  import cordic_pkg::*;

  localparam int unsigned S_W     = $clog2(WIDTH);
  localparam int unsigned EXP_TOP = EXP_BIAS + WIDTH - 1 - FRAC_BITS;

  f2f_state_e       state, state_next;
  logic             sign, sign_next;
  logic [WIDTH-1:0] mag, mag_next;
  logic [S_W-1:0]   s, s_next;
  logic             in_ready_next;
  logic             out_valid_next;
  logic [31:0]      out_data_next;
  logic [31:0]      packed_c;

  fx2fl_round_pack #(
    .MAG_W   (WIDTH),
    .S_W     (S_W),
    .EXP_TOP (EXP_TOP)
  ) u_round_pack (
    .sign     (sign),
    .mag      (mag),
    .s        (s),
    .result_c (packed_c)
  );

`ifdef FIXED_TO_FLOAT_FAST_NORM_EN
  logic [S_W-1:0] lz_c;

  // Leading-zero count; the highest set bit wins. Zero magnitude leaves 0.
  always_comb begin
    lz_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (mag[i]) lz_c = S_W'(int'(WIDTH) - 1 - i);
    end
  end
`endif

  always_comb begin
    state_next     = state;
    sign_next      = sign;
    mag_next       = mag;
    s_next         = s;
    out_valid_next = out_valid;
    out_data_next  = out_data;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_next  = in_data[WIDTH-1];
          mag_next   = in_data[WIDTH-1] ? WIDTH'(~in_data + WIDTH'(1)) : in_data;
          s_next     = '0;
          state_next = NORM;
        end
      end
      NORM: begin
`ifdef FIXED_TO_FLOAT_FAST_NORM_EN
        mag_next   = mag << lz_c;
        s_next     = lz_c;
        state_next = PACK;
`else
        if (mag[WIDTH-1] || (mag == '0)) begin
          state_next = PACK;
        end else begin
          mag_next = mag << 1;
          s_next   = s + S_W'(1);
        end
`endif
      end
      PACK: begin
        out_data_next  = packed_c;
        out_valid_next = 1'b1;
        state_next     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    in_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sign      <= 1'b0;
      mag       <= '0;
      s         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_next;
      sign      <= sign_next;
      mag       <= mag_next;
      s         <= s_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
    end
  end

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed and randomised checks of fixed_to_float: values, latency, rounding,
// backpressure, streaming order and mid-conversion reset.
module tb_fixed_to_float;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int tests  = 0;
  int failed = 0;

  fixed_to_float dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic int exp_latency(input int s);
`ifdef FIXED_TO_FLOAT_FAST_NORM_EN
    return 2 + 0 * s;
`else
    return s + 2;
`endif
  endfunction

  // Reference conversion by explicit leading-one search and remainder rounding.
  function automatic logic [31:0] model(input logic [31:0] x);
    longint v, sig, rem, half;
    int p, sh;
    logic sg;
    sg = x[31];
    v = longint'($signed(x));
    if (v < 0) v = -v;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 33; i++) if (v[i]) p = i;
    if (p <= 23) begin
      sig = v << (23 - p);
    end else begin
      sh   = p - 23;
      sig  = v >> sh;
      rem  = v & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && sig[0])) sig = sig + 1;
      if (sig[24]) begin
        sig = sig >> 1;
        p = p + 1;
      end
    end
    return {sg, 8'(p + 97), sig[22:0]};
  endfunction

  task automatic convert(input logic [31:0] din, input logic [31:0] exp_d,
                         input int s_exp, input string name);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests++;
    if (!out_valid) begin
      failed++;
      $display("FAIL %s timeout: out_valid never rose", name);
    end
    tests++;
    if (out_data !== exp_d) begin
      failed++;
      $display("FAIL %s data: got %08h expected %08h", name, out_data, exp_d);
    end
    tests++;
    if (lat !== exp_latency(s_exp)) begin
      failed++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_latency(s_exp));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset: out_valid=%b out_data=%08h in_ready=%b expected 0/00000000/1",
               out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_values();
    convert(32'h4000_0000, 32'h3F80_0000, 1,  "one");
    convert(32'hC000_0000, 32'hBF80_0000, 1,  "minus_one");
    convert(32'h8000_0000, 32'hC000_0000, 0,  "minus_two");
    convert(32'h0000_0001, 32'h3080_0000, 31, "lsb");
    convert(32'hFFFF_FFFF, 32'hB080_0000, 31, "minus_lsb");
    convert(32'h0000_0000, 32'h0000_0000, 0,  "zero");
    convert(32'h2000_0000, 32'h3F00_0000, 2,  "half");
  endtask

  task automatic test_rounding();
    convert(32'h4000_0040, 32'h3F80_0000, 1, "tie_even");
    convert(32'h4000_00C0, 32'h3F80_0002, 1, "tie_odd");
    convert(32'h3FFF_FFFF, 32'h3F80_0000, 2, "carry_exp");
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    held = out_data;
    tests++;
    if (held !== 32'h3F80_0000) begin
      failed++;
      $display("FAIL bp_data: got %08h expected 3f800000", held);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h2000_0000;
      tests++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        failed++;
        $display("FAIL bp_hold[%0d]: out_valid=%b out_data=%08h in_ready=%b expected 1/%08h/0",
                 i, out_valid, out_data, in_ready, held);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL bp_ignored_input: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    int received = 0;
    int errs = 0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] v;
          int waitc;
          v = $urandom >> $urandom_range(0, 31);
          if (i % 7 == 3) v = -v;
          @(negedge clk);
          in_valid = 1'b1;
          in_data  = v;
          q.push_back(model(v));
          waitc = 0;
          while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int cyc = 0;
        while (received < 1000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          if (out_valid && out_ready) begin
            logic [31:0] e;
            e = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
            received++;
            tests++;
            if (out_data !== e) begin
              failed++;
              errs++;
              if (errs <= 10)
                $display("FAIL stream[%0d]: got %08h expected %08h", received - 1, out_data, e);
            end
          end
        end
      end
    join
    out_ready = 1'b0;
    tests++;
    if (received !== 1000 || q.size() !== 0) begin
      failed++;
      $display("FAIL stream_count: received %0d left %0d expected 1000/0", received, q.size());
    end
  endtask

  task automatic test_reset_mid_norm();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL mid_reset: out_valid=%b out_data=%08h in_ready=%b expected 0/00000000/1",
               out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    convert(32'h2000_0000, 32'h3F00_0000, 2, "after_reset");
  endtask

  initial begin
    test_reset();
    test_values();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_norm();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
